// File: rtl/window_sequencer_if.sv
// Handshake and bus bundle between the 7x7 window sequencer, its pixel
// source, the sliding-window buffer and the downstream filter kernel.
interface window_sequencer_if #(
    parameter int DATA_W = 10,
    parameter int XW     = 10,
    parameter int YW     = 9
);
    // Upstream pixel stream
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    // Window buffer control
    logic              buf_shift_en;
    logic [DATA_W-1:0] buf_data;

    // Window strobe towards the filter kernel
    logic              win_valid;
    logic              win_ready;
    logic [XW-1:0]     win_x;
    logic [YW-1:0]     win_y;
    logic              win_border;
    logic              frame_done;

    // Sequencer side
    modport master (
        input  in_valid, in_sof, in_data, win_ready,
        output in_ready, buf_shift_en, buf_data,
        output win_valid, win_x, win_y, win_border, frame_done
    );

    // Environment side: pixel source, buffer and kernel
    modport slave (
        output in_valid, in_sof, in_data, win_ready,
        input  in_ready, buf_shift_en, buf_data,
        input  win_valid, win_x, win_y, win_border, frame_done
    );
endinterface

// File: rtl/window_sequencer.sv
// Window sequencer for a WIN x WIN sliding-window pixel buffer.
// Accepts one raster frame, shifts it into the buffer, primes and flushes
// the line delays, and reports one handshaked window per frame pixel with
// its centre coordinates and a border flag.
// Optional feature: define WINSEQ_RESYNC_EN to let an in_sof transfer in
// mid-frame abort the current frame, restart on that pixel and pulse sync_err.
module window_sequencer #(
    parameter int DATA_W     = 10,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int WIN        = 7,
    parameter int XW         = $clog2(IMG_WIDTH),
    parameter int YW         = $clog2(IMG_HEIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    window_sequencer_if.master  bus
`ifdef WINSEQ_RESYNC_EN
    ,
    output logic                sync_err
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    // R: window radius; D: pushes needed before the first centre reaches
    // the middle of the buffer; N: pixels per frame.
    localparam int R  = (WIN - 1) / 2;
    localparam int D  = R * IMG_WIDTH + R;
    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int KW = $clog2(N + D + 1);

    localparam logic [KW-1:0] K_ONE       = KW'(1);
    localparam logic [KW-1:0] K_FIRST_WIN = KW'(D + 1);
    localparam logic [KW-1:0] K_LAST_PIX  = KW'(N);
    localparam logic [KW-1:0] K_LAST      = KW'(N + D);

    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_LO   = XW'(R);
    localparam logic [XW-1:0] X_HI   = XW'(IMG_WIDTH - 1 - R);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [YW-1:0] Y_LO   = YW'(R);
    localparam logic [YW-1:0] Y_HI   = YW'(IMG_HEIGHT - 1 - R);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [1:0]        state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [XW-1:0]     cx_q, cx_d;
    logic [YW-1:0]     cy_q, cy_d;
    logic              win_valid_q, win_valid_d;
    logic [XW-1:0]     win_x_q, win_x_d;
    logic [YW-1:0]     win_y_q, win_y_d;
    logic              win_border_q, win_border_d;
    logic              frame_done_q, frame_done_d;
`ifdef WINSEQ_RESYNC_EN
    logic              sync_err_q, sync_err_d;
`endif

    logic              slot_free;
    logic              push;
    logic              restart;
    logic              in_ready_c;
    logic [DATA_W-1:0] buf_data_c;
    logic [KW-1:0]     k_inc;
    logic              centre_on_border;

    // The output slot can take a new window when empty or being consumed now.
    assign slot_free = !win_valid_q || bus.win_ready;
    assign k_inc     = k_q + K_ONE;

    // The next centre is on the border when any window tap falls outside the frame.
    assign centre_on_border = (cx_q < X_LO) || (cx_q > X_HI) ||
                              (cy_q < Y_LO) || (cy_q > Y_HI);

    // Upstream handshake and buffer drive, combinational from state and slot.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
        in_ready_c = 1'b0;
        push       = 1'b0;
        restart    = 1'b0;
        buf_data_c = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    in_ready_c = 1'b1;
                    buf_data_c = bus.in_data;
                    push       = bus.in_valid && bus.in_sof;
                    restart    = push;
                end
                STREAM: begin
                    in_ready_c = slot_free;
                    buf_data_c = bus.in_data;
                    push       = bus.in_valid && slot_free;
`ifdef WINSEQ_RESYNC_EN
                    restart    = push && bus.in_sof;
`endif
                end
                FLUSH: begin
                    push = slot_free;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state: frame FSM, push counter, centre counters and window register.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        win_valid_d  = win_valid_q;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        win_border_d = win_border_q;
        frame_done_d = 1'b0;
`ifdef WINSEQ_RESYNC_EN
        sync_err_d   = 1'b0;
`endif

        // A consumed window drops unless a push below replaces it.
        if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end

        if (restart) begin
            // This pixel becomes pixel 0 of a fresh frame.
            k_d         = K_ONE;
            cx_d        = '0;
            cy_d        = '0;
            win_valid_d = 1'b0;
            state_d     = STREAM;
`ifdef WINSEQ_RESYNC_EN
            sync_err_d  = (state_q == STREAM);
`endif
        end else if (push) begin
            k_d = k_inc;
            // Once the buffer is primed, every push completes the window of the next centre.
            if (k_inc >= K_FIRST_WIN) begin
                win_valid_d  = 1'b1;
                win_x_d      = cx_q;
                win_y_d      = cy_q;
                win_border_d = centre_on_border;
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    cy_d = (cy_q == Y_LAST) ? '0 : cy_q + Y_ONE;
                end else begin
                    cx_d = cx_q + X_ONE;
                end
            end
            if (state_q == STREAM && k_inc == K_LAST_PIX) begin
                state_d = FLUSH;
            end
            if (state_q == FLUSH && k_inc == K_LAST) begin
                state_d = DRAIN;
            end
        end

        // The frame ends once the last window has left the output slot.
        if (state_q == DRAIN && slot_free) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            win_border_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            win_border_q <= win_border_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef WINSEQ_RESYNC_EN
    // Resynchronisation error pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err = sync_err_q;
`endif

    assign bus.in_ready     = in_ready_c;
    assign bus.buf_shift_en = push;
    assign bus.buf_data     = buf_data_c;
    assign bus.win_valid    = win_valid_q;
    assign bus.win_x        = win_x_q;
    assign bus.win_y        = win_y_q;
    assign bus.win_border   = win_border_q;
    assign bus.frame_done   = frame_done_q;

endmodule
